// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead receive FIFO.
// The RX line is synchronised, then framed by a four-state FSM that samples
// each bit in its middle. Completed frames are pushed as {FERR, PERR, data}.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int K_W         = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX,
    input  logic [K_W-1:0]         k,
    input  logic                   EIGHT,
    input  logic                   PEN,
    input  logic                   OHEL,
    input  logic                   RD,
    input  logic                   CLR,
    output logic [7:0]             DATA_OUT,
    output logic                   PERR,
    output logic                   FERR,
    output logic                   RXRDY,
    output logic                   FULL,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVF
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [K_W-1:0] K_MIN = K_W'(4);
    localparam logic [K_W-1:0] K_ONE = K_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;
    state_t                 state_q, state_d;
    logic [K_W-1:0]         cnt_q, cnt_d, kq_q, kq_d, k_eff;
    logic [3:0]             bits_q, bits_d, nbits;
    logic [8:0]             shreg_q, shreg_d;
    logic                   eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic                   push;
    logic [7:0]             rx_data;
    logic                   rx_par, rx_perr;
    logic [9:0]             rx_entry;

    logic [9:0]             mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   pop, do_push, full, not_empty;
    logic [9:0]             head;

    assign rxs = sync_q[SYNC_STAGES-1];

    // Synchroniser shift, effective bit time and assembly of the frame entry.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], RX};
        k_eff    = (k < K_MIN) ? K_MIN : k;
        nbits    = 4'd7 + {3'b000, eight_q} + {3'b000, pen_q};
        rx_data  = eight_q ? shreg_q[7:0] : {1'b0, shreg_q[6:0]};
        rx_par   = eight_q ? shreg_q[8] : shreg_q[7];
        rx_perr  = pen_q & (rx_par ^ (^rx_data) ^ ohel_q);
        rx_entry = {~rxs, rx_perr, rx_data};
    end

    // Receive FSM: next state, bit counter, sample capture and push strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        kq_d    = kq_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                kq_d    = k_eff;
                eight_d = EIGHT;
                pen_d   = PEN;
                ohel_d  = OHEL;
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = k_eff >> 1;
                    bits_d  = 4'd0;
                    shreg_d = 9'd0;
                end
            end
            START: begin
                if (cnt_q == K_ONE) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = kq_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - K_ONE;
                end
            end
            DATA: begin
                if (cnt_q == K_ONE) begin
                    shreg_d[bits_q] = rxs;
                    cnt_d           = kq_q;
                    if (bits_q == nbits - 4'd1) begin
                        state_d = STOP;
                    end else begin
                        bits_d = bits_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - K_ONE;
                end
            end
            STOP: begin
                if (cnt_q == K_ONE) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - K_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver registers; frame-format and data registers need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
        end
        kq_q    <= kq_d;
        shreg_q <= shreg_d;
        eight_q <= eight_d;
        pen_q   <= pen_d;
        ohel_q  <= ohel_d;
    end

    // FIFO control: a push into a full FIFO only succeeds alongside a pop.
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = RD & not_empty;
        do_push   = push & (~full | pop);
        wr_ptr_d  = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (do_push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
        ovf_d = ovf_q;
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (CLR) begin
            ovf_d = 1'b0;
        end
        head = mem_q[rd_ptr_q];
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; the slot being popped may be rewritten when full.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_entry;
        end
    end

    assign RXRDY    = not_empty;
    assign FULL     = full;
    assign COUNT    = count_q;
    assign OVF      = ovf_q;
    assign DATA_OUT = not_empty ? head[7:0] : 8'd0;
    assign PERR     = not_empty & head[8];
    assign FERR     = not_empty & head[9];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are generated from a byte-level
// description, and a queue model of the FIFO is compared every cycle.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int K_W   = 19;
    localparam int SS    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           RX;
    logic [K_W-1:0] k;
    logic           EIGHT, PEN, OHEL;
    logic           RD, CLR;
    logic [7:0]     DATA_OUT;
    logic           PERR, FERR, RXRDY, FULL, OVF;
    logic [CW-1:0]  COUNT;

    logic rd_man, clr_man, rd_rnd, clr_rnd, rand_en;
    int   rd_thr;

    assign RD  = rd_man | (rand_en & rd_rnd);
    assign CLR = clr_man | (rand_en & clr_rnd);

    typedef struct {
        int         cyc;
        logic [9:0] ent;
    } pend_t;

    pend_t      pend[$];
    logic [9:0] q[$];
    logic       ovf_m;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    int         last_push = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .K_W(K_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .RX(RX), .k(k), .EIGHT(EIGHT), .PEN(PEN),
        .OHEL(OHEL), .RD(RD), .CLR(CLR), .DATA_OUT(DATA_OUT), .PERR(PERR),
        .FERR(FERR), .RXRDY(RXRDY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
            if (errors >= 50) finish_run();
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame; the expected entry and its push cycle are queued for the model.
    task automatic send_frame(input logic [7:0] d, input bit par, input bit stp,
                              input int kk, input bit e8, input bit pe, input bit oh,
                              input bit rd_at_push, input bit clr_at_push);
        int         kq, n, c0;
        logic [7:0] dm;
        bit         pr;
        pend_t      p;
        k = K_W'(kk); EIGHT = e8; PEN = pe; OHEL = oh;
        wait_cycles(1);
        kq = (kk < 4) ? 4 : kk;
        n  = 7 + int'(e8) + int'(pe);
        dm = e8 ? d : {1'b0, d[6:0]};
        pr = pe && (par != ((^dm) ^ oh));
        c0 = cyc;
        p.cyc = c0 + SS + 1 + kq / 2 + (n + 1) * kq;
        p.ent = {~stp, pr, dm};
        pend.push_back(p);
        last_push = p.cyc;
        RX = 1'b0;
        wait_cycles(kq);
        for (int i = 0; i < (e8 ? 8 : 7); i++) begin
            RX = dm[i];
            wait_cycles(kq);
        end
        if (pe) begin
            RX = par;
            wait_cycles(kq);
        end
        RX = stp;
        for (int j = 0; j < kq; j++) begin
            rd_man  = (cyc == p.cyc - 1) && rd_at_push;
            clr_man = (cyc == p.cyc - 1) && clr_at_push;
            wait_cycles(1);
        end
        rd_man = 1'b0; clr_man = 1'b0;
        RX = 1'b1;
        if (!stp) wait_cycles(2 * kq);
    endtask

    task automatic wait_push();
        while (cyc < last_push) wait_cycles(1);
    endtask

    task automatic pop_one();
        rd_man = 1'b1;
        wait_cycles(1);
        rd_man = 1'b0;
    endtask

    // Reference model: occupancy queue, pushes at their scheduled cycles.
    initial begin
        bit         pop, have, ovf_ev;
        logic [9:0] e;
        ovf_m = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                q.delete();
                pend.delete();
                ovf_m = 1'b0;
            end else begin
                pop    = RD && (q.size() > 0);
                have   = (pend.size() > 0) && (pend[0].cyc == cyc);
                ovf_ev = 1'b0;
                if (pop) void'(q.pop_front());
                if (have) begin
                    e = pend[0].ent;
                    pend.delete(0);
                    if (q.size() < DEPTH) q.push_back(e);
                    else ovf_ev = 1'b1;
                end
                if (ovf_ev) ovf_m = 1'b1;
                else if (CLR) ovf_m = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        logic [CW+12:0] act_v, exp_v;
        logic [9:0]     hd;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                hd = '0;
                if (q.size() > 0) hd = q[0];
                exp_v = {CW'(q.size()), q.size() > 0, q.size() == DEPTH, ovf_m, hd};
                act_v = {COUNT, RXRDY, FULL, OVF, FERR, PERR, DATA_OUT};
                chk("cycle_outputs", 32'(act_v), 32'(exp_v));
            end
        end
    end

    // Random RD/CLR generators, active only in the randomized phase.
    initial begin
        rd_rnd = 1'b0; clr_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_rnd  = ($urandom_range(0, 255) < rd_thr);
            clr_rnd = ($urandom_range(0, 63) == 0);
        end
    end

    initial begin
        #900000;
        checks++;
        errors++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        finish_run();
    end

    initial begin
        rst = 1'b1; RX = 1'b1; k = K_W'(16); EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        rd_man = 1'b0; clr_man = 1'b0; rand_en = 1'b0; rd_thr = 0;
        wait_cycles(3);
        chk_en = 1'b1;
        chk("rst_rxrdy", 32'(RXRDY), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_data", 32'(DATA_OUT), 32'd0);
        rst = 1'b0;
        wait_cycles(5);

        // 8N1 frame
        send_frame(8'hA5, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("a5_rxrdy", 32'(RXRDY), 32'd1);
        chk("a5_data", 32'(DATA_OUT), 32'hA5);
        chk("a5_perr", 32'(PERR), 32'd0);
        chk("a5_ferr", 32'(FERR), 32'd0);
        chk("a5_count", 32'(COUNT), 32'd1);
        pop_one();
        chk("a5_pop_rxrdy", 32'(RXRDY), 32'd0);

        // 7-bit even parity
        send_frame(8'h41, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("p41_data", 32'(DATA_OUT), 32'h41);
        chk("p41_perr_bad", 32'(PERR), 32'd1);
        pop_one();
        send_frame(8'h41, 1'b0, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("p41_perr_ok", 32'(PERR), 32'd0);
        pop_one();

        // framing error then a clean frame
        send_frame(8'h3C, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("f3c_ferr", 32'(FERR), 32'd1);
        chk("f3c_data", 32'(DATA_OUT), 32'h3C);
        pop_one();
        send_frame(8'h5A, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("f5a_ferr", 32'(FERR), 32'd0);
        chk("f5a_data", 32'(DATA_OUT), 32'h5A);
        pop_one();

        // overflow
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        wait_push();
        chk("ovf_full", 32'(FULL), 32'd1);
        chk("ovf_count", 32'(COUNT), 32'd4);
        chk("ovf_flag", 32'(OVF), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_data", 32'(DATA_OUT), 32'(i));
            pop_one();
        end
        chk("ovf_drained", 32'(RXRDY), 32'd0);
        clr_man = 1'b1;
        wait_cycles(1);
        clr_man = 1'b0;
        chk("ovf_clr", 32'(OVF), 32'd0);

        // push with pop while full, then overflow with simultaneous CLR
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send_frame(8'h14, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fullrd_count", 32'(COUNT), 32'd4);
        chk("fullrd_ovf", 32'(OVF), 32'd0);
        chk("fullrd_head", 32'(DATA_OUT), 32'h11);
        send_frame(8'h15, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("setwins_ovf", 32'(OVF), 32'd1);
        clr_man = 1'b1;
        wait_cycles(1);
        clr_man = 1'b0;
        chk("setwins_clr", 32'(OVF), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("fullrd_pop_data", 32'(DATA_OUT), 32'h10 + 32'(i));
            pop_one();
        end
        pop_one();
        chk("empty_rd_count", 32'(COUNT), 32'd0);

        // glitch shorter than half a bit
        k = K_W'(16);
        RX = 1'b0;
        wait_cycles(3);
        RX = 1'b1;
        wait_cycles(40);
        chk("glitch_count", 32'(COUNT), 32'd0);
        send_frame(8'h77, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("glitch_next", 32'(DATA_OUT), 32'h77);

        // reset in the middle of a frame
        RX = 1'b0; wait_cycles(16);
        RX = 1'b1; wait_cycles(16);
        RX = 1'b0; wait_cycles(16);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0; RX = 1'b1;
        chk("midrst_count", 32'(COUNT), 32'd0);
        wait_cycles(40);
        send_frame(8'hC3, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_push();
        chk("midrst_next", 32'(DATA_OUT), 32'hC3);
        chk("midrst_cnt1", 32'(COUNT), 32'd1);
        pop_one();

        // randomized frames: slow drain first, then fast drain
        rand_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            rd_thr = (f < 15) ? 2 : 64;
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                       int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b0, 1'b0);
            wait_cycles(int'($urandom_range(0, 3)));
        end
        wait_push();
        rand_en = 1'b0;
        wait_cycles(20);
        finish_run();
    end
endmodule
